// File: rtl/pkt_read_pkg.sv
// Shared types, default parameters and the circular-address helper for pkt_read_sequencer.
package pkt_read_pkg;

  localparam int unsigned DEF_PACKAGE_LENGTH = 518;
  localparam int unsigned DEF_MEMORY_DEPTH   = 24576;
  localparam int unsigned DEF_N_CHANNELS     = 16;
  localparam int unsigned DEF_ADDR_W         = 15;
  localparam int unsigned DEF_CH_W           = 4;
  localparam int unsigned DEF_CNT_W          = 12;
  localparam int unsigned DEF_QUEUE_W        = 6;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Next address in a buffer whose depth need not be a power of two.
  function automatic int unsigned addr_inc(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/pkt_read_sequencer_queue.sv
// Saturating pending-packet counter with sticky overflow (pkt_queue_counter).
module pkt_queue_counter #(
  parameter int unsigned QUEUE_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               dec,
  output logic [QUEUE_W-1:0] count,
  output logic               overflow
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count == '1) overflow <= 1'b1;
      else             count    <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pkt_read_sequencer.sv
// Replays each queued packet from a circular buffer once per channel.
// Optional channel mask input enabled by defining PKT_READ_CHANNEL_MASK_EN.
module pkt_read_sequencer
  import pkt_read_pkg::*;
#(
  parameter int unsigned PACKAGE_LENGTH = DEF_PACKAGE_LENGTH,
  parameter int unsigned MEMORY_DEPTH   = DEF_MEMORY_DEPTH,
  parameter int unsigned N_CHANNELS     = DEF_N_CHANNELS,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned CH_W           = DEF_CH_W,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned QUEUE_W        = DEF_QUEUE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read_start,
  input  logic               rd_ready,
`ifdef PKT_READ_CHANNEL_MASK_EN
  input  logic [N_CHANNELS-1:0] ch_mask,
`endif
  output logic               ren,
  output logic [ADDR_W-1:0]  raddr,
  output logic [CH_W-1:0]    input_id,
  output logic               first_word,
  output logic               last_word,
  output logic [QUEUE_W-1:0] n_mem_queue,
  output logic               queue_overflow,
  output logic               busy
);

  state_t            state;
  logic [ADDR_W-1:0] init_addr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W:0]   init_sum;
  logic [ADDR_W-1:0] init_next;
  logic [CH_W-1:0]   next_id;
  logic [CH_W-1:0]   first_id;
  logic              has_next;
  logic              word_last;
  logic              xfer;
  logic              retire;

  assign word_last  = (cnt == CNT_W'(PACKAGE_LENGTH - 1));
  assign xfer       = (state == READ) && ren && rd_ready;
  assign first_word = ren && (cnt == '0);
  assign last_word  = ren && word_last;
  assign busy       = (state != IDLE);

  assign init_sum  = {1'b0, init_addr} + (ADDR_W+1)'(PACKAGE_LENGTH);
  assign init_next = (init_sum >= (ADDR_W+1)'(MEMORY_DEPTH))
                   ? ADDR_W'(init_sum - (ADDR_W+1)'(MEMORY_DEPTH))
                   : init_sum[ADDR_W-1:0];

`ifdef PKT_READ_CHANNEL_MASK_EN
  logic [N_CHANNELS-1:0] mask_q;

  // Downward scans so the lowest qualifying channel wins.
  always_comb begin
    has_next = 1'b0;
    next_id  = input_id;
    first_id = '0;
    for (int unsigned i = N_CHANNELS; i > 0; i--) begin
      if (mask_q[i-1] && ((i - 1) > 32'(input_id))) begin
        has_next = 1'b1;
        next_id  = CH_W'(i - 1);
      end
      if (ch_mask[i-1]) first_id = CH_W'(i - 1);
    end
  end

  // An all-zero latched mask enters READ with ren low and retires next cycle.
  assign retire = (state == READ) && ((xfer && word_last && !has_next) || !ren);
`else
  always_comb begin
    has_next = (input_id < CH_W'(N_CHANNELS - 1));
    next_id  = input_id + 1'b1;
    first_id = '0;
  end

  assign retire = xfer && word_last && !has_next;
`endif

  pkt_queue_counter #(.QUEUE_W(QUEUE_W)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (read_start),
    .dec      (retire),
    .count    (n_mem_queue),
    .overflow (queue_overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ren       <= 1'b0;
      raddr     <= '0;
      input_id  <= '0;
      cnt       <= '0;
      init_addr <= '0;
`ifdef PKT_READ_CHANNEL_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (n_mem_queue != '0) begin
            state    <= READ;
            raddr    <= init_addr;
            cnt      <= '0;
            input_id <= first_id;
`ifdef PKT_READ_CHANNEL_MASK_EN
            mask_q   <= ch_mask;
            ren      <= |ch_mask;
`else
            ren      <= 1'b1;
`endif
          end
        end
        READ: begin
          if (retire) begin
            state     <= IDLE;
            ren       <= 1'b0;
            init_addr <= init_next;
          end else if (xfer) begin
            if (!word_last) begin
              raddr <= ADDR_W'(addr_inc(32'(raddr), MEMORY_DEPTH));
              cnt   <= cnt + 1'b1;
            end else begin
              raddr    <= init_addr;
              cnt      <= '0;
              input_id <= next_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_read_sequencer.sv
// Randomized bench for pkt_read_sequencer against a packet-level transfer-list model.
module tb_pkt_read_sequencer;

  localparam int PKG   = 4;
  localparam int DEPTH = 10;
  localparam int NCH   = 3;
  localparam int QW    = 2;
  localparam int QMAX  = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read_start = 1'b0;
  logic          rd_ready = 1'b1;
  logic          ren;
  logic [3:0]    raddr;
  logic [1:0]    input_id;
  logic          first_word, last_word;
  logic [QW-1:0] n_mem_queue;
  logic          queue_overflow;
  logic          busy;
`ifdef PKT_READ_CHANNEL_MASK_EN
  logic [NCH-1:0] ch_mask = 3'b111;
`endif

  pkt_read_sequencer #(
    .PACKAGE_LENGTH (PKG),
    .MEMORY_DEPTH   (DEPTH),
    .N_CHANNELS     (NCH),
    .ADDR_W         (4),
    .CH_W           (2),
    .CNT_W          (2),
    .QUEUE_W        (QW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_start     (read_start),
    .rd_ready       (rd_ready),
`ifdef PKT_READ_CHANNEL_MASK_EN
    .ch_mask        (ch_mask),
`endif
    .ren            (ren),
    .raddr          (raddr),
    .input_id       (input_id),
    .first_word     (first_word),
    .last_word      (last_word),
    .n_mem_queue    (n_mem_queue),
    .queue_overflow (queue_overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each started packet becomes the full list of transfers it must produce.
  typedef struct { int addr; int id; bit first; bit last; } xfer_t;
  typedef struct { int addr; int id; } seen_t;
  xfer_t exp_q[$];
  seen_t seen[$];
  int    m_pend, m_base;
  bit    m_ovf, m_active, m_retire, model_valid = 0;
  int    m_mask;
  int    gap = 0;
  bit    count_gaps = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = 0; m_ovf = 0; m_base = 0; m_active = 0;
      exp_q.delete();
      model_valid = 1;
    end else begin
      m_retire = 0;
      if (m_active) begin
        if (exp_q.size() == 0) m_retire = 1;
        else if (rd_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_retire = 1;
        end
        if (m_retire) begin
          m_active = 0;
          m_base = (m_base + PKG) % DEPTH;
        end
      end else if (m_pend > 0) begin
        m_active = 1;
`ifdef PKT_READ_CHANNEL_MASK_EN
        m_mask = int'(ch_mask);
`else
        m_mask = (1 << NCH) - 1;
`endif
        for (int ch = 0; ch < NCH; ch++)
          if (m_mask[ch])
            for (int w = 0; w < PKG; w++)
              exp_q.push_back('{(m_base + w) % DEPTH, ch, w == 0, w == PKG - 1});
      end
      if (read_start && !m_retire) begin
        if (m_pend == QMAX) m_ovf = 1;
        else m_pend++;
      end else if (m_retire && !read_start) begin
        m_pend--;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      automatic bit exp_ren = m_active && (exp_q.size() > 0);
      chk("ren", int'(ren), int'(exp_ren));
      chk("busy", int'(busy), int'(m_active));
      chk("n_mem_queue", int'(n_mem_queue), m_pend);
      chk("queue_overflow", int'(queue_overflow), int'(m_ovf));
      if (exp_ren) begin
        chk("raddr", int'(raddr), exp_q[0].addr);
        chk("input_id", int'(input_id), exp_q[0].id);
        chk("first_word", int'(first_word), int'(exp_q[0].first));
        chk("last_word", int'(last_word), int'(exp_q[0].last));
      end else begin
        chk("first_word_idle", int'(first_word), 0);
        chk("last_word_idle", int'(last_word), 0);
      end
      if (ren && rd_ready) seen.push_back('{int'(raddr), int'(input_id)});
      if (count_gaps && !ren && seen.size() == 12) gap++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    read_start = 1'b1;
    step();
    read_start = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      step();
      if (!busy && n_mem_queue == '0) break;
    end
    chk("drain_timeout", int'(i < maxc), 1);
  endtask

  int wrap_exp[4];

  initial begin
    wrap_exp[0] = 8; wrap_exp[1] = 9; wrap_exp[2] = 0; wrap_exp[3] = 1;
    step(); step();
    rst_n = 1'b1;
    chk("rst_ren", int'(ren), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_queue", int'(n_mem_queue), 0);
    chk("rst_busy", int'(busy), 0);

    // Single packet, two-cycle start latency
    seen.delete();
    pulse();
    chk("lat_ren_c1", int'(ren), 0);
    chk("lat_queue_c1", int'(n_mem_queue), 1);
    step();
    chk("lat_ren_c2", int'(ren), 1);
    drain(40);
    chk("pkt1_count", seen.size(), 12);
    for (int i = 0; i < 12 && i < seen.size(); i++) begin
      chk("pkt1_addr", seen[i].addr, i % 4);
      chk("pkt1_id", seen[i].id, i / 4);
    end

    // Two back-to-back packets; the second wraps the buffer
    seen.delete();
    gap = 0;
    count_gaps = 1;
    pulse();
    pulse();
    drain(80);
    count_gaps = 0;
    chk("wrap_count", seen.size(), 24);
    chk("wrap_gap", gap, 1);
    for (int i = 0; i < 4 && seen.size() >= 16; i++)
      chk("wrap_addr", seen[12 + i].addr, wrap_exp[i]);

    // Saturate the queue while stalled
    rd_ready = 1'b0;
    repeat (4) pulse();
    chk("sat_queue", int'(n_mem_queue), 3);
    chk("sat_ovf", int'(queue_overflow), 1);
    chk("sat_raddr", int'(raddr), 2);
    chk("sat_ren", int'(ren), 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rd_ready   = ($urandom_range(0, 3) != 0);
      read_start = ($urandom_range(0, 15) == 0);
`ifdef PKT_READ_CHANNEL_MASK_EN
      if (!busy) ch_mask = 3'($urandom_range(0, 7));
`endif
      step();
    end
    read_start = 1'b0;
    rd_ready   = 1'b1;
`ifdef PKT_READ_CHANNEL_MASK_EN
    ch_mask = 3'b111;
`endif
    chk("ovf_sticky", int'(queue_overflow), 1);

    // Reset in the middle of a pass
    pulse();
    for (int i = 0; i < 20 && !ren; i++) step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_ren", int'(ren), 0);
    chk("mid_rst_raddr", int'(raddr), 0);
    chk("mid_rst_id", int'(input_id), 0);
    chk("mid_rst_queue", int'(n_mem_queue), 0);
    chk("mid_rst_ovf", int'(queue_overflow), 0);
    seen.delete();
    pulse();
    drain(40);
    chk("post_rst_count", seen.size(), 12);
    if (seen.size() > 0) chk("post_rst_addr0", seen[0].addr, 0);

`ifdef PKT_READ_CHANNEL_MASK_EN
    seen.delete();
    ch_mask = 3'b101;
    pulse();
    drain(40);
    chk("mask101_count", seen.size(), 8);
    if (seen.size() == 8) begin
      chk("mask101_id_lo", seen[3].id, 0);
      chk("mask101_id_hi", seen[4].id, 2);
      chk("mask101_addr", seen[4].addr, 4);
    end
    seen.delete();
    ch_mask = 3'b000;
    pulse();
    drain(20);
    chk("mask0_count", seen.size(), 0);
    ch_mask = 3'b111;
    pulse();
    drain(40);
    if (seen.size() > 0) chk("mask0_advance", seen[0].addr, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
